// File: rtl/alu_pkg.sv
// Shared constants for the sequenced ALU: opcodes, FLAGS bit positions, FSM encodings.
package alu_pkg;

  localparam logic [3:0] OP_NOT = 4'd0;
  localparam logic [3:0] OP_XOR = 4'd1;
  localparam logic [3:0] OP_OR  = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_ADD = 4'd5;
  localparam logic [3:0] OP_RR  = 4'd6;
  localparam logic [3:0] OP_RL  = 4'd7;
  localparam logic [3:0] OP_DEC = 4'd8;
  localparam logic [3:0] OP_INC = 4'd9;
  localparam logic [3:0] OP_LD  = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;
  localparam logic [3:0] OP_RRN = 4'd12;
  localparam logic [3:0] OP_RLN = 4'd13;

  // FLAGS = {N,V,C,Z}
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per clock.
// done is high during the final step; product is valid combinationally while done=1.
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [DWIDTH-1:0]     a,
  input  logic [DWIDTH-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic [2*DWIDTH-1:0]   product
);

  localparam int CW = $clog2(DWIDTH + 1);

  logic [2*DWIDTH-1:0] acc;
  logic [2*DWIDTH-1:0] mcand;
  logic [2*DWIDTH-1:0] acc_nxt;
  logic [DWIDTH-1:0]   mplier;
  logic [CW-1:0]       cnt;
  logic                busy_q;

  // Partial-product accumulate for the current multiplier LSB
  always_comb begin
    acc_nxt = acc;
    if (mplier[0]) acc_nxt = acc + mcand;
  end

  // Load operands on start, then shift one bit per cycle while the down-counter runs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
    end else if (start && !busy_q) begin
      acc    <= '0;
      mcand  <= {{DWIDTH{1'b0}}, a};
      mplier <= b;
      cnt    <= CW'(DWIDTH);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
      if (cnt == CW'(1)) busy_q <= 1'b0;
    end
  end

  assign busy    = busy_q;
  assign done    = busy_q && (cnt == CW'(1));
  assign product = acc_nxt;

endmodule

// File: rtl/alu_seq.sv
// Sequenced ALU: single-cycle logic/arith/rotate ops, iterative MUL.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   IDLE    | ready; single-cycle ops complete on the accept edge
//   MUL     | multiplier iterating; new requests ignored
module alu_seq
  import alu_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int IWIDTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [IWIDTH-1:0] IN_INSTR,
  input  logic [DWIDTH-1:0] IN_A,
  input  logic [DWIDTH-1:0] IN_B,
  output logic [DWIDTH-1:0] OUT,
  output logic [DWIDTH-1:0] OUT_HI,
  output logic              OUT_VALID,
  output logic [3:0]        FLAGS,
  output logic              ERR
);

  localparam int                MSB  = DWIDTH - 1;
  localparam logic [DWIDTH-1:0] DW_V = DWIDTH'(DWIDTH);

  logic [0:0]          state;
  logic                accept;
  logic                reserved;
  logic                is_mul;
  logic [3:0]          op;
  logic [DWIDTH-1:0]   opnd;
  logic [DWIDTH:0]     sum_ext;
  logic [DWIDTH:0]     dif_ext;
  logic [DWIDTH-1:0]   rot_n;
  logic [DWIDTH-1:0]   rrn;
  logic [DWIDTH-1:0]   rln;
  logic [DWIDTH-1:0]   res;
  logic                c_f;
  logic                v_f;
  logic [3:0]          flags_alu;
  logic [3:0]          flags_mul;
  logic                mul_busy;
  logic                mul_done;
  logic [2*DWIDTH-1:0] mul_prod;

  assign op       = IN_INSTR[3:0];
  // Anything above RLN (including any nonzero upper opcode bits) is reserved
  assign reserved = IN_INSTR > IWIDTH'(OP_RLN);
  assign is_mul   = !reserved && (op == OP_MUL);
  assign IN_READY = (state == ST_IDLE) && !mul_busy;
  assign accept   = IN_VALID && IN_READY;

  alu_mul_iter #(.DWIDTH(DWIDTH)) u_mul (
    .CLK     (CLK),
    .RST     (RST),
    .start   (accept && is_mul),
    .a       (IN_A),
    .b       (IN_B),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Shared adder/subtractor operand and rotate-by-N datapath
  always_comb begin
    opnd = IN_B;
    if (op == OP_INC || op == OP_DEC) opnd = DWIDTH'(1);
    sum_ext = {1'b0, IN_A} + {1'b0, opnd};
    dif_ext = {1'b0, IN_A} - {1'b0, opnd};
    rot_n   = IN_B % DW_V;
    rrn     = DWIDTH'({IN_A, IN_A} >> rot_n);
    rln     = DWIDTH'(({IN_A, IN_A} << rot_n) >> DWIDTH);
  end

  // Single-cycle result and C/V selection
  always_comb begin
    res = '0;
    c_f = 1'b0;
    v_f = 1'b0;
    case (op)
      OP_NOT: res = ~IN_A;
      OP_XOR: res = IN_A ^ IN_B;
      OP_OR:  res = IN_A | IN_B;
      OP_AND: res = IN_A & IN_B;
      OP_SUB, OP_DEC: begin
        res = dif_ext[DWIDTH-1:0];
        c_f = dif_ext[DWIDTH];
        v_f = (IN_A[MSB] != opnd[MSB]) && (dif_ext[MSB] != IN_A[MSB]);
      end
      OP_ADD, OP_INC: begin
        res = sum_ext[DWIDTH-1:0];
        c_f = sum_ext[DWIDTH];
        v_f = (IN_A[MSB] == opnd[MSB]) && (sum_ext[MSB] != IN_A[MSB]);
      end
      OP_RR: begin
        res = {IN_A[0], IN_A[DWIDTH-1:1]};
        c_f = IN_A[0];
      end
      OP_RL: begin
        res = {IN_A[DWIDTH-2:0], IN_A[MSB]};
        c_f = IN_A[MSB];
      end
      OP_LD: res = IN_A;
      // Last bit rotated out ends up in the result MSB (right) or LSB (left)
      OP_RRN: begin
        res = rrn;
        c_f = (rot_n != '0) && rrn[MSB];
      end
      OP_RLN: begin
        res = rln;
        c_f = (rot_n != '0) && rln[0];
      end
      default: res = '0;
    endcase
  end

  // Flag vectors for the single-cycle path and the multiplier completion
  always_comb begin
    flags_alu         = '0;
    flags_alu[FLAG_N] = res[MSB];
    flags_alu[FLAG_V] = v_f;
    flags_alu[FLAG_C] = c_f;
    flags_alu[FLAG_Z] = (res == '0);
    flags_mul         = '0;
    flags_mul[FLAG_N] = mul_prod[2*DWIDTH-1];
    flags_mul[FLAG_V] = (mul_prod[2*DWIDTH-1:DWIDTH] != '0);
    flags_mul[FLAG_C] = (mul_prod[2*DWIDTH-1:DWIDTH] != '0);
    flags_mul[FLAG_Z] = (mul_prod == '0);
  end

  // FSM and result registers; outputs hold until the next result
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      OUT       <= '0;
      OUT_HI    <= '0;
      FLAGS     <= '0;
      ERR       <= 1'b0;
      OUT_VALID <= 1'b0;
    end else begin
      OUT_VALID <= 1'b0;
      if (state == ST_IDLE) begin
        if (accept) begin
          if (reserved) begin
            OUT       <= '0;
            OUT_HI    <= '0;
            ERR       <= 1'b1;
            OUT_VALID <= 1'b1;
          end else if (is_mul) begin
            state <= ST_MUL;
          end else begin
            OUT       <= res;
            OUT_HI    <= '0;
            FLAGS     <= flags_alu;
            ERR       <= 1'b0;
            OUT_VALID <= 1'b1;
          end
        end
      end else if (mul_done) begin
        state     <= ST_IDLE;
        OUT       <= mul_prod[DWIDTH-1:0];
        OUT_HI    <= mul_prod[2*DWIDTH-1:DWIDTH];
        FLAGS     <= flags_mul;
        ERR       <= 1'b0;
        OUT_VALID <= 1'b1;
      end
    end
  end

endmodule
